// File: rtl/race_pkg.sv
// Shared types and constants for the race_ctrl two-player light race.
// Optional false-start detection is enabled with RACE_CTRL_FALSE_START_EN (see race_ctrl).
package race_pkg;

  localparam int POS_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_COUNT = 3'd2,
    ST_RACE  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // Advance a car by step, clamping at the finish line.
  function automatic logic [POS_W-1:0] sat_step(input logic [POS_W-1:0] pos,
                                                input logic [POS_W-1:0] step,
                                                input logic [POS_W-1:0] lim);
    logic [POS_W:0] sum;
    sum = {1'b0, pos} + {1'b0, step};
    if (sum >= {1'b0, lim}) begin
      sat_step = lim;
    end else begin
      sat_step = sum[POS_W-1:0];
    end
  endfunction

endpackage

// File: rtl/race_ms_timer.sv
// Tick-gated, clearable millisecond counter that saturates at all ones.
// Used both for the countdown lamps and for the elapsed race time.
module race_ms_timer
  import race_pkg::*;
#(
  parameter int W = POS_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         tick,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Clear wins over counting; a full counter stays full.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (tick && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/race_ctrl.sv
// Two-player race controller: start key, three-lamp countdown, tick-paced race, winner.
// Define RACE_CTRL_FALSE_START_EN to end the race when a player throttles during the countdown.
module race_ctrl
  import race_pkg::*;
#(
  parameter logic [POS_W-1:0] TRACK_LEN = 16'd4000,
  parameter int               LIGHT_MS  = 1000,
  parameter logic [POS_W-1:0] STEP      = 16'd2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1khz,
  input  logic             key_start,
  input  logic             gas_p1,
  input  logic             gas_p2,
  output logic [2:0]       lights,
  output logic             go,
  output logic [POS_W-1:0] pos_p1,
  output logic [POS_W-1:0] pos_p2,
  output logic [POS_W-1:0] race_ms,
  output logic [1:0]       winner,
  output logic [2:0]       state
);

  localparam logic [POS_W-1:0] LIGHT1 = POS_W'(LIGHT_MS);
  localparam logic [POS_W-1:0] LIGHT2 = POS_W'(2 * LIGHT_MS);
  localparam logic [POS_W-1:0] LIGHT3 = POS_W'(3 * LIGHT_MS);

  state_e           state_q, state_d;
  logic             key_q;
  logic [2:0]       lights_q, lights_d;
  logic             go_q, go_d;
  logic [POS_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0]       win_q, win_d;

  logic             key_rise, cd_tick, race_tick, tmr_clr;
  logic             p1_fin, p2_fin, false_p1, false_p2;
  logic [POS_W-1:0] cd_cnt, cd_next, p1_step, p2_step;

  assign key_rise  = key_start & ~key_q;
  assign cd_tick   = tick_1khz & (state_q == ST_COUNT);
  assign race_tick = tick_1khz & (state_q == ST_RACE);
  assign tmr_clr   = (state_d == ST_ARM);

  // Lamp decisions look at the count as it will be after this clock's tick.
  assign cd_next = cd_cnt + {{(POS_W-1){1'b0}}, cd_tick};
  assign p1_step = gas_p1 ? sat_step(p1_q, STEP, TRACK_LEN) : p1_q;
  assign p2_step = gas_p2 ? sat_step(p2_q, STEP, TRACK_LEN) : p2_q;
  assign p1_fin  = gas_p1 & (p1_step == TRACK_LEN);
  assign p2_fin  = gas_p2 & (p2_step == TRACK_LEN);

`ifdef RACE_CTRL_FALSE_START_EN
  assign false_p1 = cd_tick & gas_p1;
  assign false_p2 = cd_tick & gas_p2;
`else
  assign false_p1 = 1'b0;
  assign false_p2 = 1'b0;
`endif

  race_ms_timer #(.W(POS_W)) u_cd_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .tick  (cd_tick),
    .count (cd_cnt)
  );

  race_ms_timer #(.W(POS_W)) u_race_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .tick  (race_tick),
    .count (race_ms)
  );

  // Next-state and next-output logic; a start edge anywhere but ARM restarts the game.
  always_comb begin
    state_d  = state_q;
    lights_d = lights_q;
    go_d     = go_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    win_d    = win_q;
    if (key_rise && (state_q != ST_ARM)) begin
      state_d  = ST_ARM;
      lights_d = 3'b000;
      go_d     = 1'b0;
      p1_d     = {POS_W{1'b0}};
      p2_d     = {POS_W{1'b0}};
      win_d    = WIN_NONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          lights_d = 3'b000;
          go_d     = 1'b0;
        end
        ST_ARM: begin
          state_d  = ST_COUNT;
          lights_d = 3'b001;
          go_d     = 1'b0;
          p1_d     = {POS_W{1'b0}};
          p2_d     = {POS_W{1'b0}};
          win_d    = WIN_NONE;
        end
        ST_COUNT: begin
          go_d = 1'b0;
          if (false_p1 || false_p2) begin
            state_d  = ST_DONE;
            lights_d = 3'b000;
            win_d    = (false_p1 && false_p2) ? WIN_TIE : (false_p1 ? WIN_P2 : WIN_P1);
          end else if (cd_tick && (cd_next == LIGHT3)) begin
            state_d  = ST_RACE;
            lights_d = 3'b000;
            go_d     = 1'b1;
          end else if (cd_next < LIGHT1) begin
            lights_d = 3'b001;
          end else if (cd_next < LIGHT2) begin
            lights_d = 3'b011;
          end else begin
            lights_d = 3'b111;
          end
        end
        ST_RACE: begin
          lights_d = 3'b000;
          if (race_tick) begin
            p1_d = p1_step;
            p2_d = p2_step;
            if (p1_fin || p2_fin) begin
              state_d = ST_DONE;
              go_d    = 1'b0;
              win_d   = (p1_fin && p2_fin) ? WIN_TIE : (p1_fin ? WIN_P1 : WIN_P2);
            end else begin
              go_d = 1'b1;
            end
          end else begin
            go_d = 1'b1;
          end
        end
        ST_DONE: begin
          lights_d = 3'b000;
          go_d     = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          lights_d = 3'b000;
          go_d     = 1'b0;
          p1_d     = {POS_W{1'b0}};
          p2_d     = {POS_W{1'b0}};
          win_d    = WIN_NONE;
        end
      endcase
    end
  end

  // State, key edge register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      key_q    <= 1'b0;
      lights_q <= 3'b000;
      go_q     <= 1'b0;
      p1_q     <= {POS_W{1'b0}};
      p2_q     <= {POS_W{1'b0}};
      win_q    <= WIN_NONE;
    end else begin
      state_q  <= state_d;
      key_q    <= key_start;
      lights_q <= lights_d;
      go_q     <= go_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      win_q    <= win_d;
    end
  end

  assign state  = state_q;
  assign lights = lights_q;
  assign go     = go_q;
  assign pos_p1 = p1_q;
  assign pos_p2 = p2_q;
  assign winner = win_q;

endmodule
